// File: rtl/mem_map_pkg.sv
// Shared memory map defaults, router state encoding and window-decode helper
// for mem_req_router.
package mem_map_pkg;

   localparam logic [31:0] RomBaseDef  = 32'h0040_0000;
   localparam logic [31:0] RamBaseDef  = 32'h1001_0000;
   localparam logic [31:0] WinBytesDef = 32'h0000_1000;
   localparam int unsigned WaitCntW    = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRomAcc,
      StRamAcc,
      StResp
   } state_e;

   // Compare before subtracting so an address below base cannot wrap into the window.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/mem_req_router_if.sv
// Request/response bus between a requester (master) and mem_req_router (slave).
interface mem_req_router_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic                  req_we;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/mem_wait_counter.sv
// Down-counter pacing RAM wait states: load, decrement, done when zero.
module mem_wait_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_req_router.sv
// Routes single requests to a ROM or RAM window, or answers with an error.
// Optional MEM_REQ_ERR_CNT_EN adds a saturating error-response counter err_cnt_o.
module mem_req_router
   import mem_map_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] ROM_BASE   = RomBaseDef,
   parameter logic [31:0] RAM_BASE   = RamBaseDef,
   parameter logic [31:0] WIN_BYTES  = WinBytesDef,
   parameter int unsigned RAM_WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef MEM_REQ_ERR_CNT_EN
   output logic [7:0]            err_cnt_o,
`endif
   mem_req_router_if.slave       bus,
   output logic                  rom_en_o,
   output logic [31:0]           rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rdata_i,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [31:0]           ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   state_e                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic rom_hit, ram_hit, aligned, req_err, rom_sel;
   logic cnt_load, cnt_dec, cnt_done;
   logic rsp_valid;

   assign rom_hit = in_window(bus.req_addr, ROM_BASE, WIN_BYTES);
   assign ram_hit = in_window(bus.req_addr, RAM_BASE, WIN_BYTES);
   assign aligned = (bus.req_addr[1:0] == 2'b00);
   assign req_err = !aligned || !(rom_hit || ram_hit) || (rom_hit && bus.req_we);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rom_sel  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (req_err) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = StResp;
               end else if (rom_hit) begin
                  rom_sel = 1'b1;
                  err_d   = 1'b0;
                  state_d = StRomAcc;
               end else begin
                  addr_d   = bus.req_addr - RAM_BASE;
                  we_d     = bus.req_we;
                  wdata_d  = bus.req_wdata;
                  cnt_load = 1'b1;
                  err_d    = 1'b0;
                  state_d  = StRamAcc;
               end
            end
         end
         StRomAcc: begin
            // Synchronous ROM: data for the strobe issued in IDLE is present now.
            rdata_d = rom_rdata_i;
            state_d = StResp;
         end
         StRamAcc: begin
            cnt_dec = 1'b1;
            if (cnt_done) begin
               rdata_d = we_q ? '0 : ram_rdata_i;
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   mem_wait_counter #(
      .Width(WaitCntW)
   ) u_wait (
      .clk       (clk),
      .reset     (reset),
      .load_i    (cnt_load),
      .load_val_i(WaitCntW'(RAM_WAIT - 1)),
      .dec_i     (cnt_dec),
      .done_o    (cnt_done)
   );

   // The ROM strobe is decoded from the live request, so mask it while reset is held.
   assign rom_en_o   = rom_sel && !reset;
   assign rom_addr_o = rom_en_o ? (bus.req_addr - ROM_BASE) : '0;

   assign ram_en_o    = (state_q == StRamAcc);
   assign ram_we_o    = ram_en_o && we_q;
   assign ram_addr_o  = ram_en_o ? addr_q : '0;
   assign ram_wdata_o = ram_en_o ? wdata_q : '0;

   assign rsp_valid     = (state_q == StResp);
   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_err   = rsp_valid && err_q;
   assign bus.rsp_rdata = rdata_q;

`ifdef MEM_REQ_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (rsp_valid && err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/mem_req_router.md
MEM_REQ_ROUTER -- requirements
Module: mem_req_router

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of data buses.
REQ-002 Parameter ROM_BASE, default 32'h0040_0000, base of ROM window.
REQ-003 Parameter RAM_BASE, default 32'h1001_0000, base of RAM window.
REQ-004 Parameter WIN_BYTES, default 32'h0000_1000, size of each window.
REQ-005 Parameter RAM_WAIT, default 2, RAM access wait cycles (range 1-15).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req_valid_i / req_ready_o  in / out  1 / 1  request handshake.
REQ-009 req_addr_i / req_we_i / req_wdata_i  in  32 / 1 / DATA_WIDTH  request address, write flag, write data.
REQ-010 rsp_valid_o / rsp_err_o / rsp_rdata_o  out  1 / 1 / DATA_WIDTH  response pulse, error flag, read data.
REQ-011 rom_en_o / rom_addr_o  out  1 / 32  ROM read strobe, window offset.
REQ-012 rom_rdata_i  in  DATA_WIDTH  ROM read data, valid the cycle after rom_en_o.
REQ-013 ram_en_o / ram_we_o / ram_addr_o / ram_wdata_o  out  1 / 1 / 32 / DATA_WIDTH  RAM strobe, write enable, offset, write data.
REQ-014 ram_rdata_i  in  DATA_WIDTH  RAM read data, valid in the last wait cycle.

Function
REQ-015 The FSM SHALL have states IDLE, ROM_ACC, RAM_ACC, RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-017 Decode SHALL be: in ROM window if ROM_BASE <= addr < ROM_BASE+WIN_BYTES, RAM likewise, otherwise unmapped; the offset is addr minus base.
REQ-018 ROM read accepted: IDLE->ROM_ACC, rom_en_o=1 for exactly that one cycle; next cycle capture rom_rdata_i, go to RESP.
REQ-019 RAM access accepted: IDLE->RAM_ACC, ram_en_o held 1 for RAM_WAIT cycles; ram_we_o, addr and wdata are held stable throughout.
REQ-020 In the last RAM_ACC cycle the block SHALL capture ram_rdata_i (reads only) and go to RESP.
REQ-021 ROM write or unmapped access SHALL go IDLE->RESP with rsp_err_o=1 and no memory strobe.
REQ-022 RESP SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-023 rsp_rdata_o SHALL be 0 for writes and errors and SHALL be held until the next response.
REQ-024 Request-to-response latency SHALL be 2 cycles for ROM, RAM_WAIT+1 for RAM, and 1 for errors.
REQ-025 req_valid_i outside IDLE SHALL be ignored and is not queued.
REQ-026 Address misalignment (addr[1:0]!=0) SHALL be treated as an error response.

Reset
REQ-027 Reset SHALL force IDLE; all strobes, rsp_valid_o and rsp_err_o are 0, and data/address outputs are 0.
REQ-028 Reset mid-access SHALL drop strobes immediately and produce no response.

Configuration
REQ-029 With MEM_REQ_ERR_CNT_EN defined, add output err_cnt_o[7:0]: it counts error responses, saturates at 255, and is cleared by reset.
REQ-030 Without MEM_REQ_ERR_CNT_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 The ROM/RAM base and window defaults and the state encoding SHALL live in shared package mem_map_pkg.
REQ-032 The RAM wait-cycle counter SHALL be sub-module mem_wait_counter (load, decrement, done flag).

Verification
REQ-033 ROM read at 32'h0040_0004: rom_en_o for 1 cycle with rom_addr_o=4; rsp_valid_o at +2 with rom_rdata_i value, err=0.
REQ-034 RAM write at 32'h1001_0010, data 32'hDEAD_BEEF, RAM_WAIT=2: ram_en_o and ram_we_o for 2 cycles with offset 0x10; rsp at +3, rdata=0.
REQ-035 ROM write at 32'h0040_0000: no strobes; rsp_valid_o and rsp_err_o at +1.
REQ-036 Unmapped 32'h2000_0000 and misaligned 32'h1001_0002: each gives an error response at +1; with the macro defined, err_cnt_o=2.
REQ-037 Reset asserted in the second RAM_ACC cycle: strobes drop asynchronously, no rsp_valid_o occurs, and req_ready_o=1 after release.
REQ-038 Back-to-back req_valid_i held high: the second request is accepted only on the cycle after the first rsp_valid_o.
